// File: rtl/alu_sched_pkg.sv
// Shared types and helpers for the ALU request scheduler: FSM states,
// the ALU flag bundle and the multiply-command decode.
package alu_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_e;

  typedef struct packed {
    logic oflow;
    logic cout;
    logic e;
    logic g;
    logic l;
    logic err;
  } flags_t;

  localparam logic [3:0] CMD_MUL_INC = 4'd9;
  localparam logic [3:0] CMD_MUL_SHL = 4'd10;

  // Multiply commands only exist in arithmetic mode; callers zero-extend cmd.
  function automatic logic is_mul(input logic [7:0] cmd, input logic mode);
    return mode && ((cmd == {4'd0, CMD_MUL_INC}) || (cmd == {4'd0, CMD_MUL_SHL}));
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first asserted request at or
// after rr_ptr, wrapping modulo NREQ. The pointer is owned by the parent.
module rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int PTR_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic [NREQ-1:0]  grant,
  output logic [PTR_W-1:0] grant_idx,
  output logic             any_req
);

  logic found;
  int   idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = (int'(rr_ptr) + i) % NREQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = PTR_W'(idx);
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/alu_req_scheduler.sv
// Shares one ALU between NREQ requesters: round-robin grant, one-cycle issue,
// latency-dependent wait, then a held valid/ready response to the winner.
module alu_req_scheduler
  import alu_sched_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int WIDTH    = 8,
  parameter int CMD_W    = 4,
  parameter int LAT_NORM = 1,
  parameter int LAT_MUL  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_opa,
  input  logic [NREQ*WIDTH-1:0] req_opb,
  input  logic [NREQ*CMD_W-1:0] req_cmd,
  input  logic [NREQ-1:0]       req_cin,
  input  logic [NREQ-1:0]       req_mode,
  output logic [NREQ-1:0]       rsp_valid,
  input  logic [NREQ-1:0]       rsp_ready,
  output logic [WIDTH:0]        rsp_res,
  output logic [5:0]            rsp_flags,
  output logic [WIDTH-1:0]      alu_opa,
  output logic [WIDTH-1:0]      alu_opb,
  output logic [CMD_W-1:0]      alu_cmd,
  output logic                  alu_cin,
  output logic                  alu_mode,
  output logic                  alu_ce,
  output logic [1:0]            alu_inp_valid,
  input  logic [WIDTH:0]        alu_res,
  input  logic                  alu_oflow,
  input  logic                  alu_cout,
  input  logic                  alu_e,
  input  logic                  alu_g,
  input  logic                  alu_l,
  input  logic                  alu_err
);

  localparam int PTR_W   = $clog2(NREQ);
  localparam int LAT_MAX = (LAT_MUL > LAT_NORM) ? LAT_MUL : LAT_NORM;
  localparam int CNT_W   = $clog2(LAT_MAX + 1);

  state_e             state, state_nxt;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   gnt_idx;
  logic [NREQ-1:0]    arb_gnt;
  logic [PTR_W-1:0]   arb_idx;
  logic               any_req;
  logic [CNT_W-1:0]   wait_cnt;
  flags_t             flags_q;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req       (req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (arb_gnt),
    .grant_idx (arb_idx),
    .any_req   (any_req)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (any_req) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (wait_cnt == CNT_W'(1)) state_nxt = S_RESP;
      S_RESP:  if (rsp_ready[gnt_idx]) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // req_ready is also forced low while reset is held, since IDLE alone would expose the grant.
  always_comb begin
    req_ready     = '0;
    rsp_valid     = '0;
    alu_ce        = 1'b0;
    alu_inp_valid = 2'b00;
    case (state)
      S_IDLE:  if (rst) req_ready = arb_gnt;
      S_ISSUE: begin
        alu_ce        = 1'b1;
        alu_inp_valid = 2'b11;
      end
      S_RESP:  rsp_valid = NREQ'(1) << gnt_idx;
      default: ;
    endcase
  end

  // Accept -> ALU pin registers; issue -> latency load; wait -> result capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr   <= '0;
      gnt_idx  <= '0;
      alu_opa  <= '0;
      alu_opb  <= '0;
      alu_cmd  <= '0;
      alu_cin  <= 1'b0;
      alu_mode <= 1'b0;
      wait_cnt <= '0;
      rsp_res  <= '0;
      flags_q  <= '0;
    end else begin
      case (state)
        S_IDLE: if (any_req) begin
          gnt_idx  <= arb_idx;
          rr_ptr   <= (arb_idx == PTR_W'(NREQ - 1)) ? '0 : arb_idx + 1'b1;
          alu_opa  <= req_opa[arb_idx*WIDTH +: WIDTH];
          alu_opb  <= req_opb[arb_idx*WIDTH +: WIDTH];
          alu_cmd  <= req_cmd[arb_idx*CMD_W +: CMD_W];
          alu_cin  <= req_cin[arb_idx];
          alu_mode <= req_mode[arb_idx];
        end
        S_ISSUE: wait_cnt <= is_mul(8'(alu_cmd), alu_mode) ? CNT_W'(LAT_MUL) : CNT_W'(LAT_NORM);
        S_WAIT: begin
          if (wait_cnt == CNT_W'(1)) begin
            rsp_res <= alu_res;
            flags_q <= '{oflow: alu_oflow, cout: alu_cout, e: alu_e,
                         g: alu_g, l: alu_l, err: alu_err};
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign rsp_flags = flags_q;

endmodule
